// File: rtl/lane_serializer.sv
// Width gearbox: one RATIO-lane word in, lanes out lane 0 first; LANE_SERIALIZER_LAST_EN adds input_last/output_last.
// Latency: first lane on output the cycle after in_fire; c cycles per word, next word loads on the last-lane cycle.
// Backpressure: output holds stable while output_ready=0; input_ready only when empty or the last lane leaves.
module lane_serializer #(
    parameter  int W_OUT = 8,
    parameter  int RATIO = 4,
    localparam int CNT_W = $clog2(RATIO + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RATIO*W_OUT-1:0] input_payload,
    input  logic [CNT_W-1:0]       input_lane_count,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [W_OUT-1:0]       output_payload
`ifdef LANE_SERIALIZER_LAST_EN
    ,
    input  logic                   input_last,
    output logic                   output_last
`endif
);

    localparam int IDX_W = $clog2(RATIO);

    typedef enum logic {
        EMPTY = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [RATIO*W_OUT-1:0]   buf_word_q, buf_word_d;
    logic [CNT_W-1:0]         buf_cnt_q, buf_cnt_d;
    logic [IDX_W-1:0]         lane_idx_q, lane_idx_d;
    logic                     buf_valid;
    logic                     last_lane;
    logic                     in_fire;
    logic                     out_fire;
    logic [RATIO-1:0][W_OUT-1:0] lanes;

    assign buf_valid = (state_q == EMIT);
    assign lanes     = buf_word_q;
    // Compare as idx+1 == cnt so an empty buffer (cnt=0) never underflows.
    assign last_lane = ((CNT_W'(lane_idx_q) + CNT_W'(1)) == buf_cnt_q);
    assign in_fire   = input_valid && input_ready;
    assign out_fire  = output_valid && output_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_word_q <= '0;
            buf_cnt_q  <= '0;
            lane_idx_q <= '0;
        end else begin
            buf_word_q <= buf_word_d;
            buf_cnt_q  <= buf_cnt_d;
            lane_idx_q <= lane_idx_d;
        end
    end

    // Next state: a new word wins over retiring the last lane, which is what removes the bubble.
    always_comb begin
        state_d    = state_q;
        buf_word_d = buf_word_q;
        buf_cnt_d  = buf_cnt_q;
        lane_idx_d = lane_idx_q;
        if (in_fire) begin
            lane_idx_d = '0;
            if (input_lane_count == '0) begin
                state_d = EMPTY;
            end else begin
                state_d    = EMIT;
                buf_word_d = input_payload;
                buf_cnt_d  = (input_lane_count > CNT_W'(RATIO)) ? CNT_W'(RATIO) : input_lane_count;
            end
        end else if (out_fire) begin
            if (last_lane) begin
                state_d    = EMPTY;
                lane_idx_d = '0;
            end else begin
                lane_idx_d = lane_idx_q + IDX_W'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        output_valid   = buf_valid;
        output_payload = lanes[lane_idx_q];
        input_ready    = !buf_valid || (output_ready && last_lane);
    end

`ifdef LANE_SERIALIZER_LAST_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (in_fire) begin
            last_d = input_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign output_last = buf_valid && last_q && last_lane;
`endif

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer: inputs change on the falling edge, outputs checked 1 time unit later.
module tb_lane_serializer;

    localparam int W_OUT = 8;
    localparam int RATIO = 4;
    localparam int CNT_W = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   input_valid;
    logic                   input_ready;
    logic [RATIO*W_OUT-1:0] input_payload;
    logic [CNT_W-1:0]       input_lane_count;
    logic                   output_valid;
    logic                   output_ready;
    logic [W_OUT-1:0]       output_payload;
`ifdef LANE_SERIALIZER_LAST_EN
    logic                   input_last;
    logic                   output_last;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lane_serializer #(.W_OUT(W_OUT), .RATIO(RATIO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .input_valid      (input_valid),
        .input_ready      (input_ready),
        .input_payload    (input_payload),
        .input_lane_count (input_lane_count),
        .output_valid     (output_valid),
        .output_ready     (output_ready),
        .output_payload   (output_payload)
`ifdef LANE_SERIALIZER_LAST_EN
        ,
        .input_last       (input_last),
        .output_last      (output_last)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic iv, input logic [31:0] pay, input logic [2:0] cnt, input logic ordy);
        @(negedge clk);
        input_valid      = iv;
        input_payload    = pay;
        input_lane_count = cnt;
        output_ready     = ordy;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [7:0] pay, input logic ir);
        check({tag, ".ovld"}, {31'd0, output_valid}, {31'd0, ov});
        check({tag, ".irdy"}, {31'd0, input_ready}, {31'd0, ir});
        if (ov) check({tag, ".pay"}, {24'd0, output_payload}, {24'd0, pay});
    endtask

    initial begin
        rst_n            = 1'b0;
        input_valid      = 1'b0;
        input_payload    = '0;
        input_lane_count = '0;
        output_ready     = 1'b0;
`ifdef LANE_SERIALIZER_LAST_EN
        input_last       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst.ovld", {31'd0, output_valid}, 32'd0);
        check("rst.irdy", {31'd0, input_ready}, 32'd1);
        check("rst.pay",  {24'd0, output_payload}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single 4-lane word, sink always ready
        step(1, 32'h44332211, 4, 1); expect_out("t1.load", 0, 8'h00, 1);
        step(0, 32'h0, 0, 1);        expect_out("t1.l0", 1, 8'h11, 0);
        step(0, 32'h0, 0, 1);        expect_out("t1.l1", 1, 8'h22, 0);
        step(0, 32'h0, 0, 1);        expect_out("t1.l2", 1, 8'h33, 0);
        step(0, 32'h0, 0, 1);        expect_out("t1.l3", 1, 8'h44, 1);
        step(0, 32'h0, 0, 1);        expect_out("t1.idle", 0, 8'h00, 1);

        // Back-to-back words: second loads on the first word's last lane
        step(1, 32'h44332211, 4, 1); expect_out("t2.load", 0, 8'h00, 1);
        step(1, 32'h88776655, 4, 1); expect_out("t2.l0", 1, 8'h11, 0);
        step(1, 32'h88776655, 4, 1); expect_out("t2.l1", 1, 8'h22, 0);
        step(1, 32'h88776655, 4, 1); expect_out("t2.l2", 1, 8'h33, 0);
        step(1, 32'h88776655, 4, 1); expect_out("t2.l3", 1, 8'h44, 1);
        step(0, 32'h0, 0, 1);        expect_out("t2.l4", 1, 8'h55, 0);
        step(0, 32'h0, 0, 1);        expect_out("t2.l5", 1, 8'h66, 0);
        step(0, 32'h0, 0, 1);        expect_out("t2.l6", 1, 8'h77, 0);
        step(0, 32'h0, 0, 1);        expect_out("t2.l7", 1, 8'h88, 1);
        step(0, 32'h0, 0, 1);        expect_out("t2.idle", 0, 8'h00, 1);

        // Backpressure holds lane 0 stable
        step(1, 32'hDDCCBBAA, 2, 1); expect_out("t3.load", 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 32'h0, 0, 0);    expect_out("t3.hold", 1, 8'hAA, 0);
        end
        step(0, 32'h0, 0, 1);        expect_out("t3.l0", 1, 8'hAA, 0);
        step(0, 32'h0, 0, 1);        expect_out("t3.l1", 1, 8'hBB, 1);
        step(0, 32'h0, 0, 1);        expect_out("t3.idle", 0, 8'h00, 1);

        // Count 0 discarded, count 1 single lane, count 7 clamps to 4
        step(1, 32'hDEADBEEF, 0, 1); expect_out("t4.zero", 0, 8'h00, 1);
        step(1, 32'h000000EE, 1, 1); expect_out("t4.after0", 0, 8'h00, 1);
        step(0, 32'h0, 0, 1);        expect_out("t4.ee", 1, 8'hEE, 1);
        step(0, 32'h0, 0, 1);        expect_out("t4.idle", 0, 8'h00, 1);
        step(1, 32'h44332211, 7, 1); expect_out("t4.c7load", 0, 8'h00, 1);
        step(0, 32'h0, 0, 1);        expect_out("t4.c7l0", 1, 8'h11, 0);
        step(0, 32'h0, 0, 1);        expect_out("t4.c7l1", 1, 8'h22, 0);
        step(0, 32'h0, 0, 1);        expect_out("t4.c7l2", 1, 8'h33, 0);
        step(0, 32'h0, 0, 1);        expect_out("t4.c7l3", 1, 8'h44, 1);
        step(0, 32'h0, 0, 1);        expect_out("t4.c7idle", 0, 8'h00, 1);
        // Count-0 word arriving on the last-lane cycle empties the block
        step(1, 32'hDDCCBBAA, 2, 1); expect_out("t4.b.load", 0, 8'h00, 1);
        step(1, 32'h12345678, 0, 1); expect_out("t4.b.l0", 1, 8'hAA, 0);
        step(1, 32'h12345678, 0, 1); expect_out("t4.b.l1", 1, 8'hBB, 1);
        step(0, 32'h0, 0, 1);        expect_out("t4.b.idle", 0, 8'h00, 1);

        // Async reset mid-word
        step(1, 32'h44332211, 4, 1); expect_out("t5.load", 0, 8'h00, 1);
        step(0, 32'h0, 0, 1);        expect_out("t5.l0", 1, 8'h11, 0);
        step(0, 32'h0, 0, 1);        expect_out("t5.l1", 1, 8'h22, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.rst.ovld", {31'd0, output_valid}, 32'd0);
        check("t5.rst.irdy", {31'd0, input_ready}, 32'd1);
        check("t5.rst.pay",  {24'd0, output_payload}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h88776655, 4, 1); expect_out("t5.reload", 0, 8'h00, 1);
        step(0, 32'h0, 0, 1);        expect_out("t5.n0", 1, 8'h55, 0);
        step(0, 32'h0, 0, 1);        expect_out("t5.n1", 1, 8'h66, 0);
        step(0, 32'h0, 0, 1);        expect_out("t5.n2", 1, 8'h77, 0);
        step(0, 32'h0, 0, 1);        expect_out("t5.n3", 1, 8'h88, 1);
        step(0, 32'h0, 0, 1);        expect_out("t5.idle", 0, 8'h00, 1);

`ifdef LANE_SERIALIZER_LAST_EN
        // Last flag marks only the final lane of a flagged word
        input_last = 1'b1;
        step(1, 32'h00332211, 3, 1); expect_out("t6.load", 0, 8'h00, 1);
        input_last = 1'b0;
        check("t6.load.last", {31'd0, output_last}, 32'd0);
        step(0, 32'h0, 0, 1);        expect_out("t6.l0", 1, 8'h11, 0);
        check("t6.l0.last", {31'd0, output_last}, 32'd0);
        step(0, 32'h0, 0, 1);        expect_out("t6.l1", 1, 8'h22, 0);
        check("t6.l1.last", {31'd0, output_last}, 32'd0);
        step(0, 32'h0, 0, 1);        expect_out("t6.l2", 1, 8'h33, 1);
        check("t6.l2.last", {31'd0, output_last}, 32'd1);
        step(1, 32'h00665544, 3, 1); expect_out("t6.b.load", 0, 8'h00, 1);
        check("t6.b.load.last", {31'd0, output_last}, 32'd0);
        step(0, 32'h0, 0, 1);        expect_out("t6.b.l0", 1, 8'h44, 0);
        check("t6.b.l0.last", {31'd0, output_last}, 32'd0);
        step(0, 32'h0, 0, 1);        expect_out("t6.b.l1", 1, 8'h55, 0);
        check("t6.b.l1.last", {31'd0, output_last}, 32'd0);
        step(0, 32'h0, 0, 1);        expect_out("t6.b.l2", 1, 8'h66, 1);
        check("t6.b.l2.last", {31'd0, output_last}, 32'd0);
        step(0, 32'h0, 0, 1);        expect_out("t6.idle", 0, 8'h00, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
